scrolling_matrix_display: RTL and testbench

SCROLLING_MATRIX_DISPLAY -- requirements
Module: scrolling_matrix_display

---
 rtl/scrolling_matrix_display.sv | 121 ++++++++++++
 tb/tb_scrolling_matrix_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/scrolling_matrix_display.sv
`default_nettype none
// ============================================================================
//  Module   : scrolling_matrix_display
//  Purpose  : Column-scanned LED matrix driver. It holds a NUM_COLS x LINES
//             framebuffer, scans one physical column per SCAN_DIV clocks and
//             can scroll the image horizontally by one column every
//             SCROLL_DIV frames.
//  Ports    : clk          - single clock, rising edge
//             reset        - synchronous, active-high reset
//             wr_en        - framebuffer column write strobe
//             wr_addr      - framebuffer column to write
//             wr_data      - column bitmap (bit i = line i lit)
//             scroll_en    - enable horizontal scrolling
//             blank        - force all lines off, scanning continues
//             column       - physical column currently driven
//             line         - registered line pattern for that column
//             frame_start  - one-cycle pulse when column wraps to 0
//  Revision : 1.0 - initial release
// ============================================================================
module scrolling_matrix_display #(
    parameter int          NUM_COLS   = 16,
    parameter int          LINES      = 4,
    parameter logic [23:0] SCAN_DIV   = 24'd10_000,
    parameter int          SCROLL_DIV = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_COLS)-1:0]  wr_addr,
    input  logic [LINES-1:0]             wr_data,
    input  logic                         scroll_en,
    input  logic                         blank,
    output logic [$clog2(NUM_COLS)-1:0]  column,
    output logic [LINES-1:0]             line,
    output logic                         frame_start
);

    localparam int COL_W = $clog2(NUM_COLS);
    localparam int PS_W  = (SCAN_DIV > 24'd1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [PS_W-1:0]  c_PS_LAST  = PS_W'(SCAN_DIV - 24'd1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [FC_W-1:0]  c_FC_LAST  = FC_W'(SCROLL_DIV - 1);

    // State
    logic [PS_W-1:0]  ps_q,  ps_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] off_q, off_d;
    logic [FC_W-1:0]  fc_q,  fc_d;
    logic [LINES-1:0] line_q, line_d;
    logic             frame_start_q, frame_start_d;
    logic [LINES-1:0] fb_q [NUM_COLS];
    logic [LINES-1:0] fb_d [NUM_COLS];

    logic             w_terminal;
    logic             w_wrap;
    logic [COL_W-1:0] w_rd_addr;

    assign w_terminal = (ps_q == c_PS_LAST);
    assign w_wrap     = w_terminal && (col_q == c_COL_LAST);
    // Power-of-two depth: the sum wraps naturally, giving the modulo for free.
    assign w_rd_addr  = col_q + off_q;

    always_comb begin
        ps_d          = w_terminal ? '0 : ps_q + 1'b1;
        col_d         = w_terminal ? col_q + 1'b1 : col_q;
        frame_start_d = w_wrap;

        // Read uses the pre-write buffer, so a same-cycle write to the
        // displayed column shows up one edge later.
        line_d = blank ? '0 : fb_q[w_rd_addr];

        // Offset only moves on the wrap edge so a frame never mixes offsets.
        off_d = off_q;
        fc_d  = fc_q;
        if (!scroll_en) begin
            fc_d = '0;
        end else if (w_wrap) begin
            if (fc_q == c_FC_LAST) begin
                fc_d  = '0;
                off_d = off_q + 1'b1;
            end else begin
                fc_d  = fc_q + 1'b1;
            end
        end

        fb_d = fb_q;
        if (wr_en) begin
            fb_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q          <= '0;
            col_q         <= '0;
            off_q         <= '0;
            fc_q          <= '0;
            line_q        <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                fb_q[i] <= '0;
            end
        end else begin
            ps_q          <= ps_d;
            col_q         <= col_d;
            off_q         <= off_d;
            fc_q          <= fc_d;
            line_q        <= line_d;
            frame_start_q <= frame_start_d;
            fb_q          <= fb_d;
        end
    end

    assign column      = col_q;
    assign line        = line_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_scrolling_matrix_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scrolling_matrix_display
//  Purpose  : Self-checking bench for scrolling_matrix_display with
//             NUM_COLS=4, LINES=4, SCAN_DIV=2, SCROLL_DIV=2. Directed steps
//             followed by random traffic, checked against a time-based
//             reference model of the display.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scrolling_matrix_display;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int SD = 2;
    localparam int FD = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [1:0]   wr_addr;
    logic [L-1:0] wr_data;
    logic         scroll_en;
    logic         blank;
    logic [1:0]   column;
    logic [L-1:0] line;
    logic         frame_start;

    scrolling_matrix_display #(
        .NUM_COLS   (N),
        .LINES      (L),
        .SCAN_DIV   (24'd2),
        .SCROLL_DIV (FD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .scroll_en   (scroll_en),
        .blank       (blank),
        .column      (column),
        .line        (line),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: display position derived from elapsed time since reset.
    int           cyc;          // cycles since reset
    int           offset;       // current scroll offset
    int           scroll_frames;// consecutive scrolled frames since last step
    logic [L-1:0] mem [N];
    logic [1:0]   exp_col;
    logic [L-1:0] exp_line;
    logic         exp_fs;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_edge();
        int  col_now;
        bit  wrap;
        if (reset) begin
            cyc           = 0;
            offset        = 0;
            scroll_frames = 0;
            for (int i = 0; i < N; i++) mem[i] = '0;
            exp_line = '0;
            exp_fs   = 1'b0;
        end else begin
            col_now  = (cyc / SD) % N;
            exp_line = blank ? '0 : mem[(col_now + offset) % N];
            wrap     = ((cyc + 1) % (SD * N)) == 0;
            exp_fs   = wrap;
            if (!scroll_en) begin
                scroll_frames = 0;
            end else if (wrap) begin
                scroll_frames++;
                if (scroll_frames == FD) begin
                    scroll_frames = 0;
                    offset        = (offset + 1) % N;
                end
            end
            if (wr_en) mem[wr_addr] = wr_data;
            cyc++;
        end
        exp_col = 2'((cyc / SD) % N);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        n_tests++;
        assert (column === exp_col) else begin
            n_fail++;
            $error("FAIL column: got %0d expected %0d (cyc %0d)", column, exp_col, cyc);
        end
        n_tests++;
        assert (line === exp_line) else begin
            n_fail++;
            $error("FAIL line: got %h expected %h (cyc %0d)", line, exp_line, cyc);
        end
        n_tests++;
        assert (frame_start === exp_fs) else begin
            n_fail++;
            $error("FAIL frame_start: got %b expected %b (cyc %0d)", frame_start, exp_fs, cyc);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        scroll_en = 1'b0; blank = 1'b0;
        @(negedge clk);

        // Reset, then hold: everything stays at zero.
        idle(2);
        reset = 1'b0;
        idle(1);
        n_tests++;
        assert (column === 2'd0 && line === 4'h0 && frame_start === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_state: got col %0d line %h fs %b expected 0 0 0", column, line, frame_start);
        end

        // Load two columns, then let the scan run one full frame plus.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hA; tick();
        wr_addr = 2'd1; wr_data = 4'h5; tick();
        wr_en = 1'b0;
        idle(12);

        // Scroll through more than eight frames so the offset wraps.
        scroll_en = 1'b1;
        idle(8 * 8 + 10);

        // Blank mid-frame, then release.
        blank = 1'b1; idle(5);
        blank = 1'b0; idle(3);

        // Write to the column currently displayed.
        wr_en = 1'b1; wr_addr = 2'((exp_col + offset) % N); wr_data = 4'hF; tick();
        wr_en = 1'b0; idle(2);

        // Reset with a simultaneous write during scroll: the write is lost.
        reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hC; tick();
        n_tests++;
        assert (column === 2'd0 && line === 4'h0 && frame_start === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_mid_scroll: got col %0d line %h fs %b expected 0 0 0", column, line, frame_start);
        end
        reset = 1'b0; wr_en = 1'b0; scroll_en = 1'b0;
        idle(10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 2'($urandom_range(0, N - 1));
            wr_data   = 4'($urandom);
            scroll_en = ($urandom_range(0, 9) != 0);
            blank     = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
